// File: rtl/alu_control_def.sv
// Shared decode definitions for the RV32IM decode/control stage.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
// Contents: ALUCTRL_* codes, RV32 opcode and funct7 constants, stage state
// encoding, the registered control bundle type and funct3 mapping helpers.
package alu_control_def;

  typedef enum logic [4:0] {
    ALUCTRL_NOP    = 5'd0,
    ALUCTRL_ADD    = 5'd1,
    ALUCTRL_SUB    = 5'd2,
    ALUCTRL_SLL    = 5'd3,
    ALUCTRL_SLT    = 5'd4,
    ALUCTRL_SLTU   = 5'd5,
    ALUCTRL_XOR    = 5'd6,
    ALUCTRL_SRL    = 5'd7,
    ALUCTRL_SRA    = 5'd8,
    ALUCTRL_OR     = 5'd9,
    ALUCTRL_AND    = 5'd10,
    ALUCTRL_BEQ    = 5'd11,
    ALUCTRL_BNE    = 5'd12,
    ALUCTRL_BLT    = 5'd13,
    ALUCTRL_BGE    = 5'd14,
    ALUCTRL_BLTU   = 5'd15,
    ALUCTRL_BGEU   = 5'd16,
    ALUCTRL_LUI    = 5'd17,
    ALUCTRL_MUL    = 5'd18,
    ALUCTRL_MULH   = 5'd19,
    ALUCTRL_MULHSU = 5'd20,
    ALUCTRL_MULHU  = 5'd21,
    ALUCTRL_DIV    = 5'd22,
    ALUCTRL_DIVU   = 5'd23,
    ALUCTRL_REM    = 5'd24,
    ALUCTRL_REMU   = 5'd25
  } alu_ctrl_t;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_CALC = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_LONG  = 2'd2
  } state_t;

  typedef struct packed {
    alu_ctrl_t  alu_ctrl;
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  // Integer ALU op from funct3; alt selects SUB/SRA.
  function automatic alu_ctrl_t base_alu(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALUCTRL_SUB : ALUCTRL_ADD;
      3'b001:  return ALUCTRL_SLL;
      3'b010:  return ALUCTRL_SLT;
      3'b011:  return ALUCTRL_SLTU;
      3'b100:  return ALUCTRL_XOR;
      3'b101:  return alt ? ALUCTRL_SRA : ALUCTRL_SRL;
      3'b110:  return ALUCTRL_OR;
      default: return ALUCTRL_AND;
    endcase
  endfunction

  // Branch compare op; 010/011 are reserved and flagged by the caller.
  function automatic alu_ctrl_t branch_alu(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALUCTRL_BEQ;
      3'b001:  return ALUCTRL_BNE;
      3'b100:  return ALUCTRL_BLT;
      3'b101:  return ALUCTRL_BGE;
      3'b110:  return ALUCTRL_BLTU;
      3'b111:  return ALUCTRL_BGEU;
      default: return ALUCTRL_NOP;
    endcase
  endfunction

  // M-extension op; funct3[2] splits multiply from divide/remainder.
  function automatic alu_ctrl_t m_alu(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALUCTRL_MUL;
      3'b001:  return ALUCTRL_MULH;
      3'b010:  return ALUCTRL_MULHSU;
      3'b011:  return ALUCTRL_MULHU;
      3'b100:  return ALUCTRL_DIV;
      3'b101:  return ALUCTRL_DIVU;
      3'b110:  return ALUCTRL_REM;
      default: return ALUCTRL_REMU;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational RV32(I/M) decoder: instruction word to control bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the wrapping stage decides when the result is captured.
// Ports: instr (32-bit word) in; bundle (ctrl_t), is_mul, is_div out.
// Build option: RV32M_EN enables M-extension decode; without it funct7=0000001
// on R-type is illegal and is_mul/is_div stay 0.
module instr_decode
  import alu_control_def::*;
(
  input  logic [31:0] instr,
  output ctrl_t       bundle,
  output logic        is_mul,
  output logic        is_div
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    bundle     = '0;
    bundle.rd  = instr[11:7];
    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];
    is_mul     = 1'b0;
    is_div     = 1'b0;
    illegal    = 1'b0;

    case (opcode)
      R_TYPE: begin
        bundle.reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          bundle.alu_ctrl = base_alu(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          bundle.alu_ctrl = base_alu(funct3, 1'b1);
`ifdef RV32M_EN
        end else if (funct7 == F7_MULDIV) begin
          bundle.alu_ctrl = m_alu(funct3);
          is_mul          = ~funct3[2];
          is_div          = funct3[2];
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      I_CALC: begin
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
        // Only the shift-immediates reserve funct7; elsewhere it is immediate.
        if (funct3 == 3'b001) begin
          if (funct7 == F7_BASE) bundle.alu_ctrl = ALUCTRL_SLL;
          else                   illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE)     bundle.alu_ctrl = ALUCTRL_SRL;
          else if (funct7 == F7_ALT) bundle.alu_ctrl = ALUCTRL_SRA;
          else                       illegal = 1'b1;
        end else begin
          bundle.alu_ctrl = base_alu(funct3, 1'b0);
        end
      end
      LUI: begin
        bundle.alu_ctrl  = ALUCTRL_LUI;
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
      end
      AUIPC: begin
        bundle.alu_ctrl  = ALUCTRL_ADD;
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
      end
      LOAD: begin
        bundle.alu_ctrl   = ALUCTRL_ADD;
        bundle.mem_to_reg = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.reg_write  = 1'b1;
      end
      STORE: begin
        bundle.alu_ctrl  = ALUCTRL_ADD;
        bundle.mem_write = 1'b1;
      end
      BRANCH: begin
        bundle.branch = 1'b1;
        if (funct3[2:1] == 2'b01) illegal = 1'b1;
        else                      bundle.alu_ctrl = branch_alu(funct3);
      end
      JAL, JALR: begin
        bundle.alu_ctrl  = ALUCTRL_ADD;
        bundle.branch    = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // Illegal words travel as inert tokens so trap logic sees them without side effects.
    if (illegal) begin
      bundle.alu_ctrl   = ALUCTRL_NOP;
      bundle.branch     = 1'b0;
      bundle.mem_to_reg = 1'b0;
      bundle.mem_write  = 1'b0;
      bundle.alu_src    = 1'b0;
      bundle.reg_write  = 1'b0;
    end
    if (bundle.rd == 5'd0) bundle.reg_write = 1'b0;
    bundle.illegal = illegal;
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered RV32IM decode/control stage between fetch buffer and execute.
// Latency: 1 cycle accept->out_valid; multiply/divide add MUL_LAT/DIV_LAT cycles.
// Backpressure: valid/ready; FULL holds the bundle while out_ready=0, LONG blocks input.
// Ports: clk, rst_n (sync, active-low), flush; in_valid/in_ready/instr upstream;
// out_valid/out_ready plus ALUCtrl, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite,
// rd, rs1, rs2, illegal downstream; busy while a long op counts down.
// Build option: RV32M_EN enables M-extension decode and the LONG countdown.
module decode_ctrl_stage
  import alu_control_def::*;
#(
  parameter int BITS    = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      ALUCtrl,
  output logic            Branch,
  output logic            MemtoReg,
  output logic            MemWrite,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            illegal,
  output logic            busy
);

  state_t state_q, state_d, entry_state;
  ctrl_t  dec_bundle, bundle_q;
  logic   dec_is_mul, dec_is_div;
  logic   accept;

  instr_decode u_instr_decode (
    .instr  (instr[31:0]),
    .bundle (dec_bundle),
    .is_mul (dec_is_mul),
    .is_div (dec_is_div)
  );

`ifdef RV32M_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic          cnt_zero;

  assign cnt_zero    = (cnt_q == '0);
  // A zero latency setting turns that op class into an ordinary single-cycle op.
  assign entry_state = ((dec_is_mul && MUL_LAT > 0) || (dec_is_div && DIV_LAT > 0))
                       ? S_LONG : S_FULL;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      if (dec_is_mul && MUL_LAT > 0)      cnt_q <= CW'(MUL_LAT - 1);
      else if (dec_is_div && DIV_LAT > 0) cnt_q <= CW'(DIV_LAT - 1);
      else                                cnt_q <= '0;
    end else if (state_q == S_LONG && !cnt_zero) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end
`else
  logic unused_long;

  assign entry_state = S_FULL;
  assign unused_long = dec_is_mul ^ dec_is_div ^ (MUL_LAT != 0) ^ (DIV_LAT != 0);
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_EMPTY: in_ready = 1'b1;
      S_FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
`ifdef RV32M_EN
      S_LONG:  busy = 1'b1;
`endif
      default: ;
    endcase

    // Flush drops anything offered in the same cycle.
    if (flush || !rst_n) in_ready = 1'b0;
    accept = in_valid && in_ready;

    case (state_q)
      S_EMPTY: if (accept) state_d = entry_state;
      S_FULL:  if (out_ready) state_d = accept ? entry_state : S_EMPTY;
`ifdef RV32M_EN
      S_LONG:  if (cnt_zero) state_d = S_FULL;
`endif
      default: state_d = S_EMPTY;
    endcase

    if (flush) state_d = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      bundle_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) bundle_q <= dec_bundle;
    end
  end

  assign ALUCtrl  = bundle_q.alu_ctrl;
  assign Branch   = bundle_q.branch;
  assign MemtoReg = bundle_q.mem_to_reg;
  assign MemWrite = bundle_q.mem_write;
  assign ALUSrc   = bundle_q.alu_src;
  assign RegWrite = bundle_q.reg_write;
  assign rd       = bundle_q.rd;
  assign rs1      = bundle_q.rs1;
  assign rs2      = bundle_q.rs2;
  assign illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: directed steps plus random words,
// checked against an ISA mask/match reference table and transaction-level timing.
// Honours RV32M_EN the same way as the design.
module tb_decode_ctrl_stage;
  import alu_control_def::*;

  localparam int TB_MUL_LAT = 2;
  localparam int TB_DIV_LAT = 32;

  // {Branch, MemtoReg, MemWrite, ALUSrc, RegWrite}
  localparam logic [4:0] EN_R  = 5'b00001;
  localparam logic [4:0] EN_I  = 5'b00011;
  localparam logic [4:0] EN_LD = 5'b01011;
  localparam logic [4:0] EN_ST = 5'b00100;
  localparam logic [4:0] EN_BR = 5'b10000;
  localparam logic [4:0] EN_J  = 5'b10011;

  localparam logic [31:0] M_OP = 32'h0000007F;
  localparam logic [31:0] M_F3 = 32'h0000707F;
  localparam logic [31:0] M_F7 = 32'hFE00707F;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  alu;
    logic [4:0]  en;
    int          lat;
  } entry_t;

  typedef struct {
    logic [4:0] alu;
    logic       br, m2r, mw, src, rw, ill;
    int         lat;
    logic [4:0] rd, rs1, rs2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, illegal, busy;
  logic [4:0]  ALUCtrl, rd, rs1, rs2;

  int     errors = 0;
  int     checks = 0;
  entry_t tbl[$];

  always #5 clk = ~clk;

  decode_ctrl_stage #(.BITS(32), .MUL_LAT(TB_MUL_LAT), .DIV_LAT(TB_DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .ALUCtrl(ALUCtrl),
    .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal), .busy(busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic void add_e(input logic [31:0] mask, input logic [31:0] match,
                                input logic [4:0] alu, input logic [4:0] en, input int lat);
    entry_t t;
    t.mask = mask; t.match = match; t.alu = alu; t.en = en; t.lat = lat;
    tbl.push_back(t);
  endfunction

  function automatic void build_table();
    add_e(M_F7, 32'h00000033, ALUCTRL_ADD,  EN_R, 0);
    add_e(M_F7, 32'h40000033, ALUCTRL_SUB,  EN_R, 0);
    add_e(M_F7, 32'h00001033, ALUCTRL_SLL,  EN_R, 0);
    add_e(M_F7, 32'h00002033, ALUCTRL_SLT,  EN_R, 0);
    add_e(M_F7, 32'h00003033, ALUCTRL_SLTU, EN_R, 0);
    add_e(M_F7, 32'h00004033, ALUCTRL_XOR,  EN_R, 0);
    add_e(M_F7, 32'h00005033, ALUCTRL_SRL,  EN_R, 0);
    add_e(M_F7, 32'h40005033, ALUCTRL_SRA,  EN_R, 0);
    add_e(M_F7, 32'h00006033, ALUCTRL_OR,   EN_R, 0);
    add_e(M_F7, 32'h00007033, ALUCTRL_AND,  EN_R, 0);
`ifdef RV32M_EN
    add_e(M_F7, 32'h02000033, ALUCTRL_MUL,    EN_R, TB_MUL_LAT);
    add_e(M_F7, 32'h02001033, ALUCTRL_MULH,   EN_R, TB_MUL_LAT);
    add_e(M_F7, 32'h02002033, ALUCTRL_MULHSU, EN_R, TB_MUL_LAT);
    add_e(M_F7, 32'h02003033, ALUCTRL_MULHU,  EN_R, TB_MUL_LAT);
    add_e(M_F7, 32'h02004033, ALUCTRL_DIV,    EN_R, TB_DIV_LAT);
    add_e(M_F7, 32'h02005033, ALUCTRL_DIVU,   EN_R, TB_DIV_LAT);
    add_e(M_F7, 32'h02006033, ALUCTRL_REM,    EN_R, TB_DIV_LAT);
    add_e(M_F7, 32'h02007033, ALUCTRL_REMU,   EN_R, TB_DIV_LAT);
`endif
    add_e(M_F3, 32'h00000013, ALUCTRL_ADD,  EN_I, 0);
    add_e(M_F3, 32'h00002013, ALUCTRL_SLT,  EN_I, 0);
    add_e(M_F3, 32'h00003013, ALUCTRL_SLTU, EN_I, 0);
    add_e(M_F3, 32'h00004013, ALUCTRL_XOR,  EN_I, 0);
    add_e(M_F3, 32'h00006013, ALUCTRL_OR,   EN_I, 0);
    add_e(M_F3, 32'h00007013, ALUCTRL_AND,  EN_I, 0);
    add_e(M_F7, 32'h00001013, ALUCTRL_SLL,  EN_I, 0);
    add_e(M_F7, 32'h00005013, ALUCTRL_SRL,  EN_I, 0);
    add_e(M_F7, 32'h40005013, ALUCTRL_SRA,  EN_I, 0);
    add_e(M_OP, 32'h00000037, ALUCTRL_LUI,  EN_I, 0);
    add_e(M_OP, 32'h00000017, ALUCTRL_ADD,  EN_I, 0);
    add_e(M_OP, 32'h00000003, ALUCTRL_ADD,  EN_LD, 0);
    add_e(M_OP, 32'h00000023, ALUCTRL_ADD,  EN_ST, 0);
    add_e(M_F3, 32'h00000063, ALUCTRL_BEQ,  EN_BR, 0);
    add_e(M_F3, 32'h00001063, ALUCTRL_BNE,  EN_BR, 0);
    add_e(M_F3, 32'h00004063, ALUCTRL_BLT,  EN_BR, 0);
    add_e(M_F3, 32'h00005063, ALUCTRL_BGE,  EN_BR, 0);
    add_e(M_F3, 32'h00006063, ALUCTRL_BLTU, EN_BR, 0);
    add_e(M_F3, 32'h00007063, ALUCTRL_BGEU, EN_BR, 0);
    add_e(M_OP, 32'h0000006F, ALUCTRL_ADD,  EN_J, 0);
    add_e(M_OP, 32'h00000067, ALUCTRL_ADD,  EN_J, 0);
  endfunction

  // First matching mask/match row wins; no match means an illegal token.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t       e;
    logic [4:0] en = 5'b0;
    e.alu = ALUCTRL_NOP; e.ill = 1'b1; e.lat = 0;
    foreach (tbl[i]) begin
      if (e.ill && ((w & tbl[i].mask) == tbl[i].match)) begin
        e.alu = tbl[i].alu; en = tbl[i].en; e.lat = tbl[i].lat; e.ill = 1'b0;
      end
    end
    {e.br, e.m2r, e.mw, e.src, e.rw} = en;
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    if (e.rd == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_bundle(input string tag, input exp_t e);
    check({tag, "_valid"},  32'(out_valid), 32'd1);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_alu"},    32'(ALUCtrl),   32'(e.alu));
    check({tag, "_branch"}, 32'(Branch),    32'(e.br));
    check({tag, "_m2r"},    32'(MemtoReg),  32'(e.m2r));
    check({tag, "_mwr"},    32'(MemWrite),  32'(e.mw));
    check({tag, "_src"},    32'(ALUSrc),    32'(e.src));
    check({tag, "_rwr"},    32'(RegWrite),  32'(e.rw));
    check({tag, "_ill"},    32'(illegal),   32'(e.ill));
    check({tag, "_rd"},     32'(rd),        32'(e.rd));
    check({tag, "_rs1"},    32'(rs1),       32'(e.rs1));
    check({tag, "_rs2"},    32'(rs2),       32'(e.rs2));
  endtask

  // Offer w until accepted; returns at the falling edge after the accept edge.
  task automatic send(input string tag, input logic [31:0] w);
    int n = 0;
    instr = w; in_valid = 1'b1; #1;
    while (!in_ready && n < 60) begin tick(); #1; n++; end
    check({tag, "_accept"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; instr = $urandom;
  endtask

  // Check latency, busy window, bundle, stability under hold, then drain.
  task automatic expect_out(input string tag, input logic [31:0] w, input int hold);
    exp_t e = ref_decode(w);
    int cyc = 1, nbusy = 0, nrdy = 0;
    #1;
    while (!out_valid && cyc < e.lat + 4) begin
      if (busy) nbusy++;
      if (in_ready) nrdy++;
      tick(); #1; cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(e.lat + 1));
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(e.lat));
    check({tag, "_rdy_while_busy"}, 32'(nrdy), 32'd0);
    check_bundle(tag, e);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick(); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_alu"},   32'(ALUCtrl),   32'(e.alu));
      check({tag, "_hold_rd"},    32'(rd),        32'(e.rd));
      check({tag, "_hold_rdy"},   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; #1;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] w_add, w_addi, w_div, w;
    exp_t        e;
    int          nvalid, nbusy, hold;

    build_table();
    w_add  = 32'h002081B3;
    w_addi = 32'h00500093;
    w_div  = 32'h027342B3;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    tick(); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_alu",       32'(ALUCtrl),   32'(ALUCTRL_NOP));
    check("rst_regwrite",  32'(RegWrite),  32'd0);
    check("rst_rd",        32'(rd),        32'd0);
    rst_n = 1'b1; #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Short op with the consumer ready.
    out_ready = 1'b1;
    send("add", w_add);
    expect_out("add", w_add, 0);

    // Divide: long op with M, illegal single-cycle token without.
    send("div", w_div);
    expect_out("div", w_div, 1);

    send("jal_x0", 32'h0000006F);
    expect_out("jal_x0", 32'h0000006F, 0);
    send("jal_x1", 32'h000000EF);
    expect_out("jal_x1", 32'h000000EF, 0);

    send("allones", 32'hFFFFFFFF);
    expect_out("allones", 32'hFFFFFFFF, 0);

    // Backpressure: next word waits, then loads back-to-back on out_ready.
    out_ready = 1'b0;
    send("bp_a", w_add);
    e = ref_decode(w_add);
    instr = w_addi; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_stall_rdy",   32'(in_ready),  32'd0);
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      check("bp_stall_rd",    32'(rd),        32'(e.rd));
      check("bp_stall_alu",   32'(ALUCtrl),   32'(e.alu));
      tick();
    end
    out_ready = 1'b1; #1;
    check("bp_release_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    check_bundle("bp_b", ref_decode(w_addi));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; #1;
    check("bp_drained", 32'(out_valid), 32'd0);

    // Flush on the fifth cycle after a divide is accepted.
    e = ref_decode(w_div);
    send("flush", w_div);
    repeat (4) tick();
    flush = 1'b1; in_valid = 1'b1; instr = w_add; #1;
    check("flush_pre_busy", 32'(busy), 32'(e.lat > 0));
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy",  32'(busy),      32'd0);
    check("flush_rdy",   32'(in_ready),  32'd1);
    nvalid = 0; nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      tick(); #1;
      if (out_valid) nvalid++;
      if (busy) nbusy++;
    end
    check("flush_no_valid", 32'(nvalid), 32'd0);
    check("flush_no_busy",  32'(nbusy),  32'd0);

    // One-cycle reset in the middle of a divide.
    send("rst_mid", w_div);
    repeat (2) tick();
    rst_n = 1'b0;
    tick(); #1;
    check("rmid_valid", 32'(out_valid), 32'd0);
    check("rmid_busy",  32'(busy),      32'd0);
    check("rmid_rdy",   32'(in_ready),  32'd0);
    check("rmid_alu",   32'(ALUCtrl),   32'(ALUCTRL_NOP));
    check("rmid_rwr",   32'(RegWrite),  32'd0);
    check("rmid_rd",    32'(rd),        32'd0);
    check("rmid_rs1",   32'(rs1),       32'd0);
    check("rmid_ill",   32'(illegal),   32'd0);
    rst_n = 1'b1; #1;
    check("rmid_idle_rdy", 32'(in_ready), 32'd1);
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      tick(); #1;
      if (out_valid) nvalid++;
    end
    check("rmid_no_valid", 32'(nvalid), 32'd0);

    // Random words: mostly legal encodings with random free fields, some raw noise.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom;
      end else begin
        int idx = $urandom_range(0, tbl.size() - 1);
        w = tbl[idx].match | ($urandom & ~tbl[idx].mask);
      end
      hold = $urandom_range(0, 2);
      out_ready = 1'($urandom_range(0, 1));
      send("rand", w);
      expect_out("rand", w, hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
